rssi_avg_ctrl: RTL and testbench

//   Sequences RSSI power averaging in the baseband RSSI path. Accepts I/Q samples via valid/ready handshake.

---
 rtl/rssi_avg_ctrl.sv | 137 +++++++++++++
 tb/tb_rssi_avg_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rssi_avg_ctrl.sv
// RSSI power averaging controller: squares I and Q through one shared external
// multiplier, accumulates a window of 2^LOG2_WIN sample powers and emits their mean.
module rssi_avg_ctrl #(
  parameter int IN_W     = 12,
  parameter int ACC_W    = 37,
  parameter int LOG2_WIN = 4,
  parameter int MUL_LAT  = 1
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     clear,
  input  logic                     smp_valid,
  input  logic signed [IN_W-1:0]   smp_i,
  input  logic signed [IN_W-1:0]   smp_q,
  output logic                     smp_ready,
  output logic signed [IN_W-1:0]   mul_a,
  output logic signed [IN_W-1:0]   mul_b,
  input  logic signed [2*IN_W-1:0] mul_p,
  output logic [2*IN_W-1:0]        rssi_out,
  output logic                     rssi_valid,
  output logic                     busy
);

  localparam int PW = 2 * IN_W;
  localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LOG2_WIN-1:0] LAST = '1;

  typedef enum logic [2:0] {IDLE, WAIT_SMP, MUL_I, MUL_Q, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [LOG2_WIN-1:0]    smp_cnt;
  logic [DW-1:0]          drain_cnt;
  logic [MUL_LAT-1:0]     vld_p;
  logic [ACC_W-1:0]       acc;
  logic signed [IN_W-1:0] i_p0, q_p0;
  logic                   accept, issue, drain_last;

  function automatic logic [ACC_W-1:0] sext_prod(input logic signed [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  function automatic logic [PW-1:0] sat_mean(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] m;
    m = a >> LOG2_WIN;
    if (m > {{(ACC_W-PW){1'b0}}, {PW{1'b1}}})
      return {PW{1'b1}};
    return m[PW-1:0];
  endfunction

  assign accept     = smp_valid & smp_ready;
  assign issue      = (state == MUL_I) || (state == MUL_Q);
  assign drain_last = (drain_cnt == '0);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_nxt = WAIT_SMP;
        WAIT_SMP: if (accept) state_nxt = MUL_I;
        MUL_I:    state_nxt = MUL_Q;
        MUL_Q:    state_nxt = DRAIN;
        DRAIN:    if (drain_last) state_nxt = (smp_cnt == LAST) ? DONE : WAIT_SMP;
        DONE:     state_nxt = cont ? WAIT_SMP : IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Operands are driven straight from the latched sample so the product issue cycle equals the state cycle
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_I: begin mul_a = i_p0; mul_b = i_p0; end
      MUL_Q: begin mul_a = q_p0; mul_b = q_p0; end
      default: ;
    endcase
  end

  // p0: sample capture
  always_ff @(posedge CLK) begin
    if (accept) begin
      i_p0 <= smp_i;
      q_p0 <= smp_q;
    end
  end

  // p1: product tagging, accumulation and window result
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      smp_ready  <= 1'b0;
      smp_cnt    <= '0;
      drain_cnt  <= '0;
      vld_p      <= '0;
      acc        <= '0;
      rssi_out   <= '0;
      rssi_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      smp_ready  <= (state_nxt == WAIT_SMP);
      rssi_valid <= 1'b0;
      if (clear) begin
        smp_cnt   <= '0;
        drain_cnt <= '0;
        vld_p     <= '0;
        acc       <= '0;
      end else begin
        vld_p <= (vld_p << 1) | MUL_LAT'(issue);
        if (vld_p[MUL_LAT-1])
          acc <= acc + sext_prod(mul_p);
        case (state)
          MUL_Q: drain_cnt <= DW'(MUL_LAT - 1);
          DRAIN: begin
            if (!drain_last)
              drain_cnt <= drain_cnt - 1'b1;
            else if (smp_cnt != LAST)
              smp_cnt <= smp_cnt + 1'b1;
          end
          DONE: begin
            rssi_out   <= sat_mean(acc);
            rssi_valid <= 1'b1;
            acc        <= '0;
            smp_cnt    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rssi_avg_ctrl.sv
// Scoreboard bench for rssi_avg_ctrl: a behavioural window-mean model predicts each
// result and its arrival cycle; a monitor compares whenever rssi_valid pulses.
module tb_rssi_avg_ctrl;
  localparam int IN_W = 12, ACC_W = 37, LOG2_WIN = 4, MUL_LAT = 1;
  localparam int WIN = 1 << LOG2_WIN;
  localparam int PW = 2 * IN_W;

  logic CLK = 0, RSTn = 0, start = 0, cont = 0, clear = 0, smp_valid = 0;
  logic signed [IN_W-1:0] smp_i = '0, smp_q = '0;
  logic smp_ready, rssi_valid, busy;
  logic signed [IN_W-1:0] mul_a, mul_b;
  logic signed [PW-1:0] mul_p;
  logic [PW-1:0] rssi_out;
  logic signed [PW-1:0] mpipe [MUL_LAT];

  int checks = 0, errors = 0;
  longint cyc = 0;
  int pulses = 0, accepts = 0;

  typedef struct { longint val; longint when; } exp_t;
  exp_t sb[$];
  longint sum = 0;
  int n = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // External multiplier model with MUL_LAT cycles of latency
  always @(posedge CLK) begin
    mpipe[0] <= mul_a * mul_b;
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  rssi_avg_ctrl #(.IN_W(IN_W), .ACC_W(ACC_W), .LOG2_WIN(LOG2_WIN), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .cont(cont), .clear(clear),
    .smp_valid(smp_valid), .smp_i(smp_i), .smp_q(smp_q), .smp_ready(smp_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rssi_out(rssi_out), .rssi_valid(rssi_valid), .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint model_mean(input longint s);
    longint m;
    m = s / WIN;
    if (m > (64'sd1 << PW) - 1) m = (64'sd1 << PW) - 1;
    return m;
  endfunction

  // Monitor: compare results, then track accepted samples into the window model
  always @(negedge CLK) begin
    exp_t e;
    if (!RSTn) begin
      sb.delete(); sum = 0; n = 0;
    end else begin
      if (rssi_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rssi_valid actual=%0d required=none", rssi_out);
        end else begin
          e = sb.pop_front();
          chk("rssi_out", longint'(rssi_out), e.val);
          chk("rssi_latency", cyc, e.when);
        end
      end
      if (clear) begin
        sb.delete(); sum = 0; n = 0;
      end else if (smp_valid && smp_ready) begin
        accepts++;
        sum += longint'(smp_i) * longint'(smp_i) + longint'(smp_q) * longint'(smp_q);
        n++;
        if (n == WIN) begin
          e.val = model_mean(sum);
          e.when = cyc + 4 + MUL_LAT;
          sb.push_back(e);
          sum = 0; n = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input int iv, input int qv, input bit rnd);
    int guard = 0;
    bit done = 0;
    while (!done) begin
      if (rnd && $urandom_range(0, 2) == 0) begin
        smp_valid = 0; smp_i = IN_W'($urandom); smp_q = IN_W'($urandom);
      end else begin
        smp_valid = 1; smp_i = IN_W'(iv); smp_q = IN_W'(qv);
      end
      done = smp_valid && smp_ready;
      tick();
      guard++;
      if (!done && guard > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=no_accept required=accept");
        done = 1;
      end
    end
    smp_valid = 0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy || sb.size() != 0) begin
      tick();
      g++;
      if (g > 100) begin
        checks++; errors++;
        $display("FAIL idle_timeout actual=busy%0d_pending%0d required=idle", busy, sb.size());
        break;
      end
    end
  endtask

  initial begin
    int p0, a0;
    repeat (2) tick();
    chk("rst_smp_ready", smp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rssi_valid", rssi_valid, 0);
    chk("rst_rssi_out", rssi_out, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    RSTn = 1; tick();

    pulse_start();
    for (int k = 0; k < WIN; k++) send(100, -50, 0);
    wait_idle();
    chk("t1_mean", rssi_out, 12500);

    pulse_start();
    for (int k = 0; k < WIN; k++) send(-2048, -2048, 0);
    wait_idle();
    chk("t2_fullscale", rssi_out, 8388608);

    pulse_start();
    for (int k = 0; k < WIN; k++) send(k, 0, 1);
    wait_idle();
    chk("t3_ramp", rssi_out, 77);

    // Abort in the DRAIN of the 9th sample
    p0 = pulses;
    pulse_start();
    for (int k = 0; k < 8; k++) send(7, 3, 0);
    send(5, 5, 0);
    tick(); tick();
    clear = 1; tick(); clear = 0;
    chk("t4_busy_after_clear", busy, 0);
    chk("t4_ready_after_clear", smp_ready, 0);
    repeat (8) tick();
    chk("t4_no_pulse", pulses, p0);
    pulse_start();
    for (int k = 0; k < WIN; k++) send(10, 10, 0);
    wait_idle();
    chk("t4_fresh", rssi_out, 200);

    // Three back-to-back windows via cont
    p0 = pulses; a0 = accepts;
    cont = 1;
    pulse_start();
    for (int k = 0; k < 3 * WIN; k++) begin
      send(3, 4, k >= WIN);
      if (k == 2 * WIN) cont = 0;
    end
    wait_idle();
    chk("t5_pulses", pulses - p0, 3);
    chk("t5_accepts", accepts - a0, 3 * WIN);
    chk("t5_mean", rssi_out, 25);

    // Random full-range windows
    for (int w = 0; w < 3; w++) begin
      pulse_start();
      for (int k = 0; k < WIN; k++)
        send($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048, 1);
      wait_idle();
    end

    // Asynchronous reset while in MUL_Q
    pulse_start();
    for (int k = 0; k < 6; k++) send(9, 9, 0);
    tick();
    #2 RSTn = 0;
    #1;
    chk("t6_ready", smp_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mul_a", mul_a, 0);
    chk("t6_mul_b", mul_b, 0);
    chk("t6_rssi_valid", rssi_valid, 0);
    chk("t6_rssi_out", rssi_out, 0);
    tick();
    RSTn = 1;
    smp_valid = 1; smp_i = 1; smp_q = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_no_ready_before_start", smp_ready, 0);
    end
    smp_valid = 0;
    pulse_start();
    for (int k = 0; k < WIN; k++) send(1, 1, 0);
    wait_idle();
    chk("t6_after_reset", rssi_out, 2);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
